// File: rtl/ivl_uvm_mbx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ivl_uvm_mbx_pkg
// Description : Shared types, constants and helpers for the bounded mailbox.
// Revision    : 1.0 - initial release
// ============================================================================
package ivl_uvm_mbx_pkg;

    typedef enum logic [0:0] {
        MBX_BLOCKING = 1'b0,
        MBX_DROP_NEW = 1'b1
    } mbx_mode_e;

    localparam int DROPW = 16;

    function automatic int mbx_cntw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ivl_uvm_bmbx_ptr.sv
`default_nettype none
// ============================================================================
// Module      : ivl_uvm_bmbx_ptr
// Description : Modulo-DEPTH pointer with explicit wrap and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module ivl_uvm_bmbx_ptr #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] c_last = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + PW'(1);
        end
    end

    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/ivl_uvm_bmbx.sv
`default_nettype none
// ============================================================================
// Module      : ivl_uvm_bmbx
// Description : Bounded FWFT mailbox with valid/ready sides, flush and a
//               selectable full-policy (block or drop-new).
// Revision    : 1.0 - initial release
// ============================================================================
module ivl_uvm_bmbx
    import ivl_uvm_mbx_pkg::*;
#(
    parameter int        WIDTH = 32,
    parameter int        DEPTH = 4,
    parameter mbx_mode_e MODE  = MBX_BLOCKING,
    parameter int        CNTW  = mbx_cntw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             put_valid,
    output logic             put_ready,
    input  logic [WIDTH-1:0] put_data,
    output logic             get_valid,
    input  logic             get_ready,
    output logic [WIDTH-1:0] get_data,
    input  logic             flush,
    output logic [CNTW-1:0]  num,
    output logic             full,
    output logic             empty,
    output logic [DROPW-1:0] drop_cnt
);

    localparam int             c_pw    = $clog2(DEPTH);
    localparam logic [CNTW-1:0] c_depth = CNTW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNTW-1:0]  r_num;
    logic [c_pw-1:0]  w_wp;
    logic [c_pw-1:0]  w_rp;
    logic             w_full;
    logic             w_empty;
    logic             w_put_ready;
    logic             w_put_fire;
    logic             w_get_fire;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_full     = (r_num == c_depth);
    assign w_empty    = (r_num == '0);
    assign w_put_fire = put_valid & w_put_ready;
    assign w_get_fire = ~w_empty & get_ready;
    // In drop mode put_ready stays high, so a fire while full must not store.
    assign w_wr_en    = w_put_fire & ~w_full & ~flush;
    assign w_rd_en    = w_get_fire & ~flush;

    ivl_uvm_bmbx_ptr #(.DEPTH(DEPTH), .PW(c_pw)) u_wp (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_wr_en),
        .clr   (flush),
        .ptr   (w_wp)
    );

    ivl_uvm_bmbx_ptr #(.DEPTH(DEPTH), .PW(c_pw)) u_rp (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_rd_en),
        .clr   (flush),
        .ptr   (w_rp)
    );

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wp] <= put_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num <= '0;
        end else if (flush) begin
            r_num <= '0;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b10:   r_num <= r_num + CNTW'(1);
                2'b01:   r_num <= r_num - CNTW'(1);
                default: r_num <= r_num;
            endcase
        end
    end

    generate
        if (MODE == MBX_DROP_NEW) begin : g_drop
            logic             w_drop;
            logic [DROPW-1:0] r_drop_cnt;

            assign w_drop = put_valid & w_full & ~flush;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_drop_cnt <= '0;
                end else if (w_drop && (r_drop_cnt != {DROPW{1'b1}})) begin
                    r_drop_cnt <= r_drop_cnt + DROPW'(1);
                end
            end

            assign w_put_ready = 1'b1;
            assign drop_cnt    = r_drop_cnt;
        end else begin : g_block
            assign w_put_ready = ~w_full;
            assign drop_cnt    = '0;
        end
    endgenerate

    assign put_ready = w_put_ready;
    assign get_valid = ~w_empty;
    assign get_data  = r_mem[w_rp];
    assign num       = r_num;
    assign full      = w_full;
    assign empty     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_ivl_uvm_bmbx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ivl_uvm_bmbx
// Description : Self-checking bench driving three mailbox variants in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ivl_uvm_bmbx;
    import ivl_uvm_mbx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pv = 1'b0;
    logic [31:0] pd = '0;
    logic        gr = 1'b0;
    logic        fl = 1'b0;

    logic [2:0]  pr, gv, fu, em;
    logic [31:0] gd [3];
    logic [15:0] dc [3];
    logic [2:0]  num_a;
    logic [1:0]  num_b;
    logic [2:0]  num_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // instance 0: DEPTH 4 blocking, 1: DEPTH 3 blocking, 2: DEPTH 4 drop-new
    ivl_uvm_bmbx #(.WIDTH(32), .DEPTH(4), .MODE(MBX_BLOCKING)) u_a (
        .clk(clk), .rst_n(rst_n), .put_valid(pv), .put_ready(pr[0]), .put_data(pd),
        .get_valid(gv[0]), .get_ready(gr), .get_data(gd[0]), .flush(fl),
        .num(num_a), .full(fu[0]), .empty(em[0]), .drop_cnt(dc[0]));
    ivl_uvm_bmbx #(.WIDTH(32), .DEPTH(3), .MODE(MBX_BLOCKING)) u_b (
        .clk(clk), .rst_n(rst_n), .put_valid(pv), .put_ready(pr[1]), .put_data(pd),
        .get_valid(gv[1]), .get_ready(gr), .get_data(gd[1]), .flush(fl),
        .num(num_b), .full(fu[1]), .empty(em[1]), .drop_cnt(dc[1]));
    ivl_uvm_bmbx #(.WIDTH(32), .DEPTH(4), .MODE(MBX_DROP_NEW)) u_c (
        .clk(clk), .rst_n(rst_n), .put_valid(pv), .put_ready(pr[2]), .put_data(pd),
        .get_valid(gv[2]), .get_ready(gr), .get_data(gd[2]), .flush(fl),
        .num(num_c), .full(fu[2]), .empty(em[2]), .drop_cnt(dc[2]));

    // Reference model: each mailbox is an ordered list; pop shifts the list.
    int          mdep  [3] = '{4, 3, 4};
    bit          mdrop [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] mq    [3][8];
    int          mcnt  [3];
    int          mdc   [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            mdc[k]  = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit was_full;
            was_full = (mcnt[k] == mdep[k]);
            if (fl) begin
                mcnt[k] = 0;
            end else begin
                if (pv && was_full && mdrop[k] && mdc[k] < 65535) mdc[k]++;
                if (gr && mcnt[k] > 0) begin
                    for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
                    mcnt[k]--;
                end
                if (pv && !was_full) begin
                    mq[k][mcnt[k]] = pd;
                    mcnt[k]++;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int num_of(input int k);
        case (k)
            0:       return int'(num_a);
            1:       return int'(num_b);
            default: return int'(num_c);
        endcase
    endfunction

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            chk("num", k, num_of(k), mcnt[k]);
            chk("full", k, fu[k], mcnt[k] == mdep[k]);
            chk("empty", k, em[k], mcnt[k] == 0);
            chk("put_ready", k, pr[k], mdrop[k] ? 1 : (mcnt[k] != mdep[k]));
            chk("get_valid", k, gv[k], mcnt[k] > 0);
            chk("drop_cnt", k, dc[k], mdc[k]);
            if (mcnt[k] > 0) chk("get_data", k, gd[k], mq[k][0]);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_num"}, k, num_of(k), 0);
            chk({tag, "_empty"}, k, em[k], 1);
            chk({tag, "_full"}, k, fu[k], 0);
            chk({tag, "_put_ready"}, k, pr[k], 1);
            chk({tag, "_get_valid"}, k, gv[k], 0);
            chk({tag, "_drop_cnt"}, k, dc[k], 0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit          pv;
        logic [31:0] pd;
        bit          gr;
        int          num;
        bit          pr;
        bit          gv;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int dc0;

        // Blocking DEPTH 4: fill, stall 0x55 while popping 0x11, then drain.
        tbl[0] = '{1, 32'h11, 0, 1, 1, 1, 32'h11};
        tbl[1] = '{1, 32'h22, 0, 2, 1, 1, 32'h11};
        tbl[2] = '{1, 32'h33, 0, 3, 1, 1, 32'h11};
        tbl[3] = '{1, 32'h44, 0, 4, 0, 1, 32'h11};
        tbl[4] = '{1, 32'h55, 1, 3, 1, 1, 32'h22};
        tbl[5] = '{1, 32'h55, 0, 4, 0, 1, 32'h22};
        tbl[6] = '{0, 32'h0,  1, 3, 1, 1, 32'h33};
        tbl[7] = '{0, 32'h0,  1, 2, 1, 1, 32'h44};
        tbl[8] = '{0, 32'h0,  1, 1, 1, 1, 32'h55};
        tbl[9] = '{0, 32'h0,  1, 0, 1, 0, 32'h0};

        model_reset();
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 10; i++) begin
            pv = tbl[i].pv; pd = tbl[i].pd; gr = tbl[i].gr;
            tick();
            chk("tbl_num", i, num_a, tbl[i].num);
            chk("tbl_put_ready", i, pr[0], tbl[i].pr);
            chk("tbl_get_valid", i, gv[0], tbl[i].gv);
            if (tbl[i].gv) chk("tbl_get_data", i, gd[0], tbl[i].data);
        end
        pv = 0; gr = 1;
        repeat (5) tick();
        gr = 0;

        // Peek: head word held while get_ready is low.
        pv = 1; pd = 32'hAB;
        tick();
        pv = 0;
        repeat (5) begin
            tick();
            chk("peek_data", 0, gd[0], 32'hAB);
            chk("peek_num", 0, num_a, 1);
        end
        gr = 1;
        tick();
        chk("peek_empty", 0, em[0], 1);
        gr = 0;

        // Drop-new: six puts into four slots.
        fl = 1; tick(); fl = 0;
        dc0 = int'(dc[2]);
        for (int v = 1; v <= 6; v++) begin
            pv = 1; pd = 32'(v);
            tick();
            chk("drop_put_ready", v, pr[2], 1);
        end
        pv = 0;
        chk("drop_cnt_delta", 2, dc[2], dc0 + 2);
        gr = 1;
        for (int v = 1; v <= 4; v++) begin
            chk("drop_contents", v, gd[2], v);
            tick();
        end
        chk("drop_drained", 2, em[2], 1);
        gr = 0;

        // Concurrent put/get across pointer wrap at occupancy 2.
        fl = 1; tick(); fl = 0;
        pv = 1;
        pd = 32'h200; tick();
        pd = 32'h201; tick();
        gr = 1;
        for (int i = 0; i < 10; i++) begin
            pd = 32'h300 + 32'(i);
            tick();
            chk("wrap_num_d4", i, num_a, 2);
            chk("wrap_num_d3", i, num_b, 2);
        end
        pv = 0; gr = 0;

        // Flush with a concurrent put.
        fl = 1; tick(); fl = 0;
        pv = 1;
        for (int i = 0; i < 3; i++) begin pd = 32'h400 + 32'(i); tick(); end
        dc0 = int'(dc[2]);
        fl = 1; pd = 32'hDEAD;
        tick();
        fl = 0; pv = 0;
        chk("flush_num_d4", 0, num_a, 0);
        chk("flush_num_d3", 1, num_b, 0);
        chk("flush_drop_cnt", 2, dc[2], dc0);
        tick();
        chk("flush_not_stored", 0, em[0], 1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            pv = ($urandom_range(0, 3) != 0);
            pd = $urandom;
            gr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 40) == 0);
            tick();
        end
        fl = 0;
        // Saturate some drops into the drop-new instance before reset.
        pv = 1; gr = 0;
        repeat (8) tick();

        // Asynchronous reset in the middle of a burst.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        pv = 0;
        @(negedge clk);
        rst_n = 1'b1;
        pv = 1; pd = 32'h77;
        tick();
        pv = 0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ivl_uvm_bmbx.md
# ivl_uvm_bmbx

Bounded, parametrised mailbox for the IVL-UVM environment. It stores up to DEPTH words of WIDTH bits in FIFO order, with a valid/ready handshake on each side. The read side is first-word fall-through, which gives non-destructive peek. It adds a full condition, an occupancy count, a flush, and a selectable full-policy (block or drop) that the unbounded queue mailbox lacks. It sits between stimulus producers and driver/scoreboard consumers.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 4, capacity in words (≥2, need not be a power of two)
- MODE, MBX_BLOCKING, full-policy: MBX_BLOCKING or MBX_DROP_NEW
- CNTW, $clog2(DEPTH+1), occupancy width (derived, not overridden)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- put_valid  in  1  producer offers put_data
- put_ready  out  1  mailbox accepts this cycle
- put_data  in  WIDTH  word to store
- get_valid  out  1  head word present on get_data
- get_ready  in  1  consumer takes head word
- get_data  out  WIDTH  head word (peek value while get_valid)
- flush  in  1  synchronous discard of all contents
- num  out  CNTW  current occupancy, 0..DEPTH
- full  out  1  num == DEPTH
- empty  out  1  num == 0
- drop_cnt  out  16  words discarded in DROP_NEW mode, saturating at 0xFFFF

## Operation
- put_fire = put_valid & put_ready; get_fire = get_valid & get_ready.
- Storage is a DEPTH-entry array with write pointer wp, read pointer rp and count num. Each pointer wraps from DEPTH-1 to 0 explicitly; it does not rely on power-of-two overflow.
- BLOCKING mode: put_ready = ~full. A producer holds put_valid and put_data stable until put_fire.
- DROP_NEW mode: put_ready = 1. put_valid while full (and no flush) discards the word, leaves contents unchanged, and increments drop_cnt if it is below 0xFFFF.
- get_valid = ~empty. get_data = mem[rp] combinationally. get_ready without get_valid is ignored.
- No bypass paths:
  - put_ready does not depend on get_ready.
  - A word written into an empty mailbox is not visible until the next cycle.
- Simultaneous put_fire and get_fire: both pointers advance and num is unchanged. When full in BLOCKING mode there is no put_fire.
- flush has priority over put and get in the same cycle. It sets wp = rp = 0 and num = 0, and does not write the offered word. drop_cnt is untouched. The producer sees put_ready per the pre-flush state but the word is lost. Drivers must not assert put_valid with flush.
- Reset values: wp = rp = 0, num = 0, empty = 1, full = 0, get_valid = 0, drop_cnt = 0. put_ready = 1 in both modes. get_data is X/don't-care while empty. Memory contents are not reset.
- Reset mid-operation: all contents are discarded immediately. Outputs take their reset values asynchronously.

## Timing
- Put-to-get latency is 1 cycle: a word accepted at edge N is on get_data with get_valid = 1 after edge N.
- Throughput is one put and one get per cycle sustained, except the full-BLOCKING stall.
- num, full, empty and put_ready update after the edge of the causing fire.
- From full in BLOCKING mode, get_fire at edge N gives put_ready = 1 after edge N.
- No combinational path from put_valid or get_ready to any output.

## Structure
- Package ivl_uvm_mbx_pkg holds:
  - the mbx_mode_e enum (MBX_BLOCKING, MBX_DROP_NEW)
  - the localparam DROPW = 16
  - the function mbx_cntw(depth) returning $clog2(depth+1)
- Sub-module ivl_uvm_bmbx_ptr: a modulo-DEPTH wrapping pointer with inputs inc and clr and output ptr. It is instantiated twice, once for wp and once for rp.
- Top level holds the array, num and drop_cnt logic, and the mode selection via generate-if.

## Test plan
- Reset then idle: num = 0, empty = 1, full = 0, put_ready = 1, get_valid = 0, drop_cnt = 0.
- DEPTH = 4, BLOCKING: put 0x11, 0x22, 0x33, 0x44 → full = 1, put_ready = 0. Then put 0x55 held while a get pops 0x11 → 0x55 is accepted the cycle after; the gets then return 0x22, 0x33, 0x44, 0x55 in order.
- Wrap and concurrency: with num = 2, put_fire and get_fire every cycle for 10 cycles → num stays at 2, and the data order is preserved across pointer wrap (DEPTH = 3 variant included).
- DROP_NEW, DEPTH = 4: 6 consecutive puts of 1..6 → drop_cnt = 2, contents are 1..4, put_ready = 1 throughout.
- Peek: one word 0xAB stored, get_ready = 0 for 5 cycles → get_data = 0xAB and num = 1 held. get_ready = 1 → empty = 1 the next cycle.
- Flush with num = 3 and concurrent put_valid → num = 0, the flushed-cycle word is not stored, drop_cnt is unchanged. rst_n dropped mid-burst → outputs return to reset values without waiting for a clock edge.
